load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 162 ++++++++++++++++
 tb/tb_load_store_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: byte/halfword/word accesses to a word-wide memory, with read-modify-write for sub-word stores.
// Optional misalignment trap enabled by defining LSU_MISALIGN_TRAP_EN; otherwise low address bits are aligned down.
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WRITE
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;

    state_t      state;
    logic        we_q;
    logic        unsigned_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] mem_wdata_q;
    logic        mem_write_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;

    logic [31:0] load_data;
    logic [31:0] merged_word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Size 11 is treated as a word, so bit 1 alone marks a word access.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] low_addr);
`ifdef LSU_MISALIGN_TRAP_EN
        if (size == SIZE_HALF)
            return low_addr[0];
        else if (size[1])
            return |low_addr;
        else
            return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    always_comb begin
        byte_sel  = 8'h00;
        half_sel  = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        load_data = mem_read_data;
        case (addr_q[1:0])
            2'b00:   byte_sel = mem_read_data[7:0];
            2'b01:   byte_sel = mem_read_data[15:8];
            2'b10:   byte_sel = mem_read_data[23:16];
            default: byte_sel = mem_read_data[31:24];
        endcase
        case (size_q)
            SIZE_BYTE: load_data = unsigned_q ? {24'h000000, byte_sel}
                                              : {{24{byte_sel[7]}}, byte_sel};
            SIZE_HALF: load_data = unsigned_q ? {16'h0000, half_sel}
                                              : {{16{half_sel[15]}}, half_sel};
            default:   load_data = mem_read_data;
        endcase
    end

    always_comb begin
        merged_word = mem_read_data;
        if (size_q == SIZE_BYTE)
            merged_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else if (size_q == SIZE_HALF)
            merged_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    // NOTE: every register here, including the request fields, is async-cleared so an abort leaves no stale write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            we_q         <= 1'b0;
            unsigned_q   <= 1'b0;
            size_q       <= 2'b00;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            mem_wdata_q  <= 32'h0;
            mem_write_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            // NOTE: non-blocking throughout so every branch sees the pre-edge register values.
            resp_valid_q <= 1'b0;
            mem_write_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q        <= req_we;
                        unsigned_q  <= req_unsigned;
                        size_q      <= req_size;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        mem_wdata_q <= req_wdata;
                        // Word stores write during ACCESS, so the enable is armed at acceptance.
                        mem_write_q <= req_we && req_size[1] && !misaligned(req_size, req_addr[1:0]);
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (misaligned(size_q, addr_q[1:0])) begin
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_rdata_q <= 32'h0;
                        state        <= IDLE;
                    end else if (!we_q) begin
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= load_data;
                        state        <= IDLE;
                    end else if (size_q[1]) begin
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= 32'h0;
                        state        <= IDLE;
                    end else begin
                        mem_wdata_q <= merged_word;
                        mem_write_q <= 1'b1;
                        state       <= WRITE;
                    end
                end
                WRITE: begin
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= 32'h0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready      = (state == IDLE);
    assign resp_valid     = resp_valid_q;
    assign resp_rdata     = resp_rdata_q;
    assign resp_err       = resp_err_q;
    assign mem_write      = mem_write_q;
    assign mem_address    = {addr_q[31:2], 2'b00};
    assign mem_write_data = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: word memory model, response scoreboard and directed steps.
// Define LSU_MISALIGN_TRAP_EN for both bench and design to exercise the trap build.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem [0:63] = '{default: 32'h0};
    int          cyc = 0;
    int          wr_count = 0;
    int          wr_edge = 0;
    int          total = 0;
    int          passed = 0;
    int          last_accept = 0;
    logic        resp_at_accept = 1'b0;

    load_store_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_address[7:2]];

    // Edge numbers: cyc+1 is the index of the edge now in progress.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_write) begin
            mem[mem_address[7:2]] <= mem_write_data;
            wr_count <= wr_count + 1;
            wr_edge  <= cyc + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && resp_valid === 1'b1) begin
            check("resp_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_err", {31'h0, resp_err}, {31'h0, e.err});
                check("resp_latency", cyc, e.due);
            end
        end
    end

    // Drives a request at the first negedge with req_ready high and returns just after the accepting edge.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rd, input logic err, input int lat, input bit expect_resp);
        int guard = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("ready_timeout", 32'(guard < 20), 32'd1);
        req_valid      = 1'b1;
        req_we         = we;
        req_size       = size;
        req_unsigned   = uns;
        req_addr       = addr;
        req_wdata      = wdata;
        last_accept    = cyc + 1;
        resp_at_accept = resp_valid;
        if (expect_resp)
            sb.push_back('{rdata: rd, err: err, due: last_accept + lat - 1});
        @(posedge clk);
    endtask

    task automatic drop();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        check("drain_empty", sb.size(), 32'd0);
    endtask

    initial begin
        int wr0;
        int acc_a;
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int wr0;
        int acc_a;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        #1;
        check("rst_req_ready", {31'h0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", {31'h0, resp_err}, 32'd0);
        check("rst_mem_write", {31'h0, mem_write}, 32'd0);
        check("rst_mem_address", mem_address, 32'h0);
        check("rst_mem_wdata", mem_write_data, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Word store then word load at 0x10.
        wr0 = wr_count;
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1);
        drop();
        drain();
        check("ws_write_count", wr_count - wr0, 32'd1);
        check("ws_write_edge", wr_edge, last_accept + 1);
        check("ws_mem", mem[4], 32'hDEADBEEF);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b1);
        drop();
        drain();
        repeat (3) @(negedge clk);
        check("rdata_hold", resp_rdata, 32'hDEADBEEF);

        // Byte store into a preloaded word: read-modify-write, write only in WRITE.
        issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 32'h0, 1'b0, 2, 1'b1);
        drop();
        drain();
        wr0 = wr_count;
        issue(1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFFFFAA, 32'h0, 1'b0, 3, 1'b1);
        drop();
        drain();
        check("bs_write_count", wr_count - wr0, 32'd1);
        check("bs_write_edge", wr_edge, last_accept + 2);
        check("bs_mem", mem[8], 32'h1122AA44);

        // Sign/zero extension of byte and halfword lanes.
        issue(1'b1, 2'b10, 1'b0, 32'h30, 32'h0000F080, 32'h0, 1'b0, 2, 1'b1);
        drop();
        issue(1'b0, 2'b00, 1'b0, 32'h30, 32'h0, 32'hFFFFFF80, 1'b0, 2, 1'b1);
        drop();
        issue(1'b0, 2'b01, 1'b1, 32'h30, 32'h0, 32'h0000F080, 1'b0, 2, 1'b1);
        drop();
        issue(1'b0, 2'b01, 1'b0, 32'h30, 32'h0, 32'hFFFFF080, 1'b0, 2, 1'b1);
        drop();
        issue(1'b0, 2'b00, 1'b1, 32'h31, 32'h0, 32'h000000F0, 1'b0, 2, 1'b1);
        drop();
        issue(1'b0, 2'b00, 1'b0, 32'h31, 32'h0, 32'hFFFFFFF0, 1'b0, 2, 1'b1);
        drop();
        issue(1'b1, 2'b01, 1'b0, 32'h32, 32'h0000BEEF, 32'h0, 1'b0, 3, 1'b1);
        drop();
        issue(1'b0, 2'b11, 1'b0, 32'h30, 32'h0, 32'hBEEFF080, 1'b0, 2, 1'b1);
        drop();
        drain();

        // Two loads with req_valid held high: second accepted in the first's response cycle.
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b1);
        acc_a = last_accept;
        issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h1122AA44, 1'b0, 2, 1'b1);
        check("b2b_accept_edge", last_accept, acc_a + 2);
        check("b2b_resp_at_accept", {31'h0, resp_at_accept}, 32'd1);
        drop();
        drain();

        // Misaligned accesses.
        issue(1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, 32'h0, 1'b0, 2, 1'b1);
        drop();
        issue(1'b1, 2'b10, 1'b0, 32'h44, 32'h00000000, 32'h0, 1'b0, 2, 1'b1);
        drop();
        drain();
`ifdef LSU_MISALIGN_TRAP_EN
        issue(1'b0, 2'b10, 1'b0, 32'h42, 32'h0, 32'h0, 1'b1, 2, 1'b1);
        drop();
        wr0 = wr_count;
        issue(1'b1, 2'b10, 1'b0, 32'h46, 32'h12345678, 32'h0, 1'b1, 2, 1'b1);
        drop();
        issue(1'b1, 2'b01, 1'b0, 32'h41, 32'h00009999, 32'h0, 1'b1, 2, 1'b1);
        drop();
        drain();
        check("mis_write_count", wr_count - wr0, 32'd0);
        check("mis_mem40", mem[16], 32'hCAFEF00D);
        check("mis_mem44", mem[17], 32'h00000000);
`else
        issue(1'b0, 2'b10, 1'b0, 32'h42, 32'h0, 32'hCAFEF00D, 1'b0, 2, 1'b1);
        drop();
        wr0 = wr_count;
        issue(1'b1, 2'b10, 1'b0, 32'h46, 32'h12345678, 32'h0, 1'b0, 2, 1'b1);
        drop();
        issue(1'b1, 2'b01, 1'b0, 32'h41, 32'h00009999, 32'h0, 1'b0, 3, 1'b1);
        drop();
        drain();
        check("mis_write_count", wr_count - wr0, 32'd2);
        check("mis_mem40", mem[16], 32'hCAFE9999);
        check("mis_mem44", mem[17], 32'h12345678);
`endif

        // Reset during WRITE of a halfword store aborts the write and the response.
        issue(1'b1, 2'b10, 1'b0, 32'h50, 32'h55667788, 32'h0, 1'b0, 2, 1'b1);
        drop();
        drain();
        wr0 = wr_count;
        issue(1'b1, 2'b01, 1'b0, 32'h52, 32'h00001234, 32'h0, 1'b0, 3, 1'b0);
        drop();
        @(negedge clk);
        check("abort_in_write", {31'h0, mem_write}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_mem_write", {31'h0, mem_write}, 32'd0);
        check("abort_req_ready", {31'h0, req_ready}, 32'd1);
        check("abort_resp_valid", {31'h0, resp_valid}, 32'd0);
        check("abort_mem_address", mem_address, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_write_count", wr_count - wr0, 32'd0);
        check("abort_mem", mem[20], 32'h55667788);
        check("abort_rdata", resp_rdata, 32'h0);

        drain();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
